// File: rtl/axi_r_cluster_splitter_pkg.sv
// Shared types and helpers for the AXI R-channel cluster splitter.
package axi_r_cluster_splitter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } split_state_e;

  // Pointer width that stays legal for a single-entry FIFO.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axi_r_cluster_splitter_r_split_fifo.sv
// Per-cluster synchronous FIFO; control is reset, storage is not.
module r_split_fifo
  import axi_r_cluster_splitter_pkg::*;
#(
  parameter int Width = 37,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o
);

  localparam int PtrW = ptr_w(Depth);
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_r_cluster_splitter.sv
// Splits aligned full-width R beats into per-cluster slices with byte strobes
// and a last flag derived from the transfer byte count; one FIFO per cluster.
module axi_r_cluster_splitter
  import axi_r_cluster_splitter_pkg::*;
#(
  parameter int NrClusters   = 4,
  parameter int AxiDataWidth = 128,
  parameter int FifoDepth    = 2,
  parameter int MaxBytes     = 4096,
  localparam int AxiBytes    = AxiDataWidth / 8,
  localparam int ClBytes     = AxiBytes / NrClusters,
  localparam int CntW        = $clog2(MaxBytes + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [CntW-1:0]                 cmd_bytes_i,
  input  logic                            r_valid_i,
  output logic                            r_ready_o,
  input  logic [AxiDataWidth-1:0]         r_data_i,
  input  logic                            r_last_i,
  output logic [NrClusters-1:0]           cl_valid_o,
  input  logic [NrClusters-1:0]           cl_ready_i,
  output logic [NrClusters*ClBytes*8-1:0] cl_data_o,
  output logic [NrClusters*ClBytes-1:0]   cl_strb_o,
  output logic [NrClusters-1:0]           cl_last_o,
  output logic                            busy_o,
  output logic                            last_err_o
);

  localparam int ClW = ClBytes * 8;

  typedef logic [CntW-1:0] cnt_t;

  typedef struct packed {
    logic [ClW-1:0]     data;
    logic [ClBytes-1:0] strb;
    logic               last;
  } r_split_entry_t;

  split_state_e    state_q;
  cnt_t            bytes_left_q;
  logic            cmd_ready_q;
  logic            busy_q;
  logic            last_err_q;
  logic            r_hs;
  logic            beat_last;
  logic [NrClusters-1:0] full;
  logic [NrClusters-1:0] empty;
  r_split_entry_t  push_entry [NrClusters];
  r_split_entry_t  pop_entry  [NrClusters];

  // Remaining byte count after one beat, clamped at zero.
  function automatic cnt_t sat_sub_beat(input cnt_t left);
    if (int'(left) > AxiBytes) return left - cnt_t'(AxiBytes);
    else return '0;
  endfunction

  assign beat_last   = (int'(bytes_left_q) <= AxiBytes);
  assign r_ready_o   = (state_q == ACTIVE) && !(|full);
  assign r_hs        = r_valid_i && r_ready_o;
  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign last_err_o  = last_err_q;

  always_comb begin
    for (int c = 0; c < NrClusters; c++) begin
      push_entry[c]      = '0;
      push_entry[c].data = r_data_i[c*ClW +: ClW];
      for (int b = 0; b < ClBytes; b++) begin
        push_entry[c].strb[b] = ((c * ClBytes + b) < int'(bytes_left_q));
      end
      push_entry[c].last = beat_last;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      bytes_left_q <= '0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      last_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A zero-byte command is accepted and dropped.
          if (cmd_valid_i && cmd_bytes_i != '0) begin
            bytes_left_q <= cmd_bytes_i;
            state_q      <= ACTIVE;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        ACTIVE: begin
          if (r_hs) begin
            bytes_left_q <= sat_sub_beat(bytes_left_q);
            if (r_last_i != beat_last) last_err_q <= 1'b1;
            if (beat_last) begin
              state_q     <= IDLE;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Cluster FIFO stage: every FIFO pushes in lockstep, pops independently.
  for (genvar c = 0; c < NrClusters; c++) begin : g_cl
    r_split_fifo #(
      .Width($bits(r_split_entry_t)),
      .Depth(FifoDepth)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (r_hs),
      .data_i (push_entry[c]),
      .full_o (full[c]),
      .pop_i  (cl_ready_i[c]),
      .data_o (pop_entry[c]),
      .empty_o(empty[c])
    );

    assign cl_valid_o[c]                  = !empty[c];
    assign cl_data_o[c*ClW +: ClW]        = pop_entry[c].data;
    assign cl_strb_o[c*ClBytes +: ClBytes] = pop_entry[c].strb;
    assign cl_last_o[c]                   = pop_entry[c].last;
  end

endmodule

// File: tb/tb_axi_r_cluster_splitter.sv
// Bench for axi_r_cluster_splitter: table vectors, directed corner cases and
// randomized traffic checked against a byte-index reference model.
module tb_axi_r_cluster_splitter;

  localparam int NC = 4;
  localparam int DW = 128;
  localparam int AB = 16;
  localparam int CB = 4;
  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [CW-1:0] cmd_bytes_i;
  logic          r_valid_i;
  logic          r_ready_o;
  logic [DW-1:0] r_data_i;
  logic          r_last_i;
  logic [NC-1:0] cl_valid_o;
  logic [NC-1:0] cl_ready_i;
  logic [NC*32-1:0] cl_data_o;
  logic [NC*CB-1:0] cl_strb_o;
  logic [NC-1:0] cl_last_o;
  logic          busy_o;
  logic          last_err_o;

  always #5 clk = ~clk;

  axi_r_cluster_splitter #(
    .NrClusters(NC), .AxiDataWidth(DW), .FifoDepth(2), .MaxBytes(4096)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_bytes_i(cmd_bytes_i),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_last_i(r_last_i),
    .cl_valid_o(cl_valid_o), .cl_ready_i(cl_ready_i), .cl_data_o(cl_data_o),
    .cl_strb_o(cl_strb_o), .cl_last_o(cl_last_o),
    .busy_o(busy_o), .last_err_o(last_err_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } exp_t;

  typedef struct {
    int          bytes;
    int          beats;
    logic [15:0] last_strb;
  } vec_t;

  exp_t        mq[NC][$];
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          mon_en = 0;
  bit          m_active = 0;
  bit          m_err = 0;
  int          m_total = 0;
  int          m_beat = 0;
  int          pop_cnt[NC] = '{default: 0};
  int          r_hs_cnt = 0;
  logic [15:0] obs_last_strb = '0;
  bit          rnd_done = 0;
  logic        exp_rr;
  logic        m_last;
  exp_t        e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: beat k of a T-byte transfer carries byte indices
  // k*AB .. k*AB+AB-1; a byte is valid when its index is below T.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_rr = m_active;
      for (int c = 0; c < NC; c++) if (mq[c].size() >= 2) exp_rr = 1'b0;
      chk("cmd_ready", 64'(cmd_ready_o), 64'(!m_active));
      chk("busy", 64'(busy_o), 64'(m_active));
      chk("last_err", 64'(last_err_o), 64'(m_err));
      chk("r_ready", 64'(r_ready_o), 64'(exp_rr));
      for (int c = 0; c < NC; c++)
        chk("cl_valid", 64'(cl_valid_o[c]), 64'(mq[c].size() > 0));
      if (rst_i) begin
        for (int c = 0; c < NC; c++) mq[c].delete();
        m_active = 0;
        m_err    = 0;
      end else begin
        for (int c = 0; c < NC; c++) begin
          if (cl_valid_o[c] && cl_ready_i[c] && mq[c].size() > 0) begin
            e = mq[c].pop_front();
            chk("cl_data", 64'(cl_data_o[c*32 +: 32]), 64'(e.data));
            chk("cl_strb", 64'(cl_strb_o[c*CB +: CB]), 64'(e.strb));
            chk("cl_last", 64'(cl_last_o[c]), 64'(e.last));
            pop_cnt[c]++;
            if (cl_last_o[c]) obs_last_strb[c*CB +: CB] = cl_strb_o[c*CB +: CB];
          end
        end
        if (r_valid_i && r_ready_o && m_active) begin
          m_last = ((m_beat + 1) * AB >= m_total);
          for (int c = 0; c < NC; c++) begin
            e.data = r_data_i[c*32 +: 32];
            for (int b = 0; b < CB; b++) e.strb[b] = (m_beat * AB + c * CB + b < m_total);
            e.last = m_last;
            mq[c].push_back(e);
          end
          if (r_last_i != m_last) m_err = 1;
          m_beat++;
          r_hs_cnt++;
          if (m_last) m_active = 0;
        end else if (cmd_valid_i && cmd_ready_o && cmd_bytes_i != '0) begin
          m_active = 1;
          m_total  = int'(cmd_bytes_i);
          m_beat   = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input int bytes);
    int g = 0;
    while (!cmd_ready_o && g < 200) begin tick(); g++; end
    if (g >= 200) chk("cmd_wait_timeout", 64'(g), 64'(0));
    cmd_valid_i = 1'b1;
    cmd_bytes_i = CW'(bytes);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic send_beats(input int n, input int last_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      if (gaps && $urandom_range(0, 2) == 0) begin r_valid_i = 1'b0; tick(); end
      r_valid_i = 1'b1;
      r_data_i  = {$urandom, $urandom, $urandom, $urandom};
      r_last_i  = (i == last_at);
      while (!r_ready_o && g < 300) begin tick(); g++; end
      if (g >= 300) chk("r_wait_timeout", 64'(g), 64'(0));
      tick();
    end
    r_valid_i = 1'b0;
    r_last_i  = 1'b0;
  endtask

  function automatic bit model_empty();
    for (int c = 0; c < NC; c++) if (mq[c].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drain();
    int g = 0;
    while (!model_empty() && g < 500) begin tick(); g++; end
    if (g >= 500) chk("drain_timeout", 64'(g), 64'(0));
    tick();
  endtask

  vec_t vt[8];
  int   b0, b2, bh;
  int   bc[NC];

  initial begin
    vt[0] = '{64, 4, 16'hFFFF};
    vt[1] = '{22, 2, 16'h003F};
    vt[2] = '{16, 1, 16'hFFFF};
    vt[3] = '{1,  1, 16'h0001};
    vt[4] = '{17, 2, 16'h0001};
    vt[5] = '{48, 3, 16'hFFFF};
    vt[6] = '{40, 3, 16'h00FF};
    vt[7] = '{31, 2, 16'h7FFF};

    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_bytes_i = '0;
    r_valid_i = 1'b0; r_data_i = '0; r_last_i = 1'b0; cl_ready_i = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst_i  = 1'b0;
    mon_en = 1;
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'(1));
    chk("rst_r_ready", 64'(r_ready_o), 64'(0));
    chk("rst_cl_valid", 64'(cl_valid_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_last_err", 64'(last_err_o), 64'(0));

    for (int i = 0; i < 8; i++) begin
      b0 = pop_cnt[0];
      obs_last_strb = '0;
      do_cmd(vt[i].bytes);
      send_beats(vt[i].beats, vt[i].beats - 1, 0);
      drain();
      chk("vec_beats", 64'(pop_cnt[0] - b0), 64'(vt[i].beats));
      chk("vec_last_strb", 64'(obs_last_strb), 64'(vt[i].last_strb));
    end

    // Stalled cluster 2 holds back the whole beat stream.
    cl_ready_i = 4'b1011;
    bh = r_hs_cnt; b0 = pop_cnt[0]; b2 = pop_cnt[2];
    do_cmd(80);
    fork
      send_beats(5, 4, 0);
      begin
        repeat (12) tick();
        chk("stall_accepted", 64'(r_hs_cnt - bh), 64'(2));
        chk("stall_r_ready", 64'(r_ready_o), 64'(0));
        chk("stall_cl0_pops", 64'(pop_cnt[0] - b0), 64'(2));
        chk("stall_cl2_pops", 64'(pop_cnt[2] - b2), 64'(0));
        cl_ready_i = 4'hF;
      end
    join
    drain();
    chk("stall_cl2_total", 64'(pop_cnt[2] - b2), 64'(5));

    // Early r_last: flag set, framing follows the byte count, flag is sticky.
    do_cmd(32);
    send_beats(2, 0, 0);
    drain();
    chk("early_last_err", 64'(last_err_o), 64'(1));
    chk("early_last_idle", 64'(busy_o), 64'(0));
    do_cmd(16);
    send_beats(1, 0, 0);
    drain();
    chk("err_sticky", 64'(last_err_o), 64'(1));

    // Reset mid-transfer with data sitting in the FIFOs.
    cl_ready_i = 4'h0;
    do_cmd(64);
    send_beats(1, 3, 0);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midrst_cl_valid", 64'(cl_valid_o), 64'(0));
    chk("midrst_cmd_ready", 64'(cmd_ready_o), 64'(1));
    chk("midrst_busy", 64'(busy_o), 64'(0));
    chk("midrst_last_err", 64'(last_err_o), 64'(0));
    cl_ready_i = 4'hF;
    b0 = pop_cnt[0];
    do_cmd(16);
    send_beats(1, 0, 0);
    drain();
    chk("postrst_beats", 64'(pop_cnt[0] - b0), 64'(1));

    // Zero-byte command followed directly by a 16-byte one.
    for (int c = 0; c < NC; c++) bc[c] = pop_cnt[c];
    obs_last_strb = '0;
    do_cmd(0);
    chk("zero_busy", 64'(busy_o), 64'(0));
    chk("zero_cmd_ready", 64'(cmd_ready_o), 64'(1));
    do_cmd(16);
    send_beats(1, 0, 0);
    drain();
    for (int c = 0; c < NC; c++) chk("zero_then16_beats", 64'(pop_cnt[c] - bc[c]), 64'(1));
    chk("zero_then16_strb", 64'(obs_last_strb), 64'(16'hFFFF));

    // Randomized traffic with random cluster backpressure.
    fork
      begin
        for (int t = 0; t < 25; t++) begin
          int bytes;
          int nb;
          bytes = $urandom_range(0, 100);
          do_cmd(bytes);
          if (bytes > 0) begin
            nb = (bytes + AB - 1) / AB;
            send_beats(nb, ($urandom_range(0, 9) == 0) ? 0 : nb - 1, 1);
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          tick();
          cl_ready_i = 4'($urandom);
        end
      end
    join
    cl_ready_i = 4'hF;
    drain();
    chk("final_empty", 64'(cl_valid_o), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
